fft_frame_loader: RTL and testbench

Streaming-to-parallel front end for the 8-point FFT core. Accepts complex Q8.8 samples one per cycle over a valid/ready stream and assembles them into 8-sample frames in a ping-pong (two-bank) buffer. Presents each completed frame on the FFT core's eight parallel complex inputs, then sequences the core's `write`/`start` controls. Releases the bank once the core signals `ready`, so one frame can fill while the previous one is being transformed.

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_frame_bank.sv | 21 ++
 rtl/fft_frame_loader.sv | 174 +++++++++++++++++
 tb/tb_fft_frame_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the 8-point FFT front end.
package fft_pkg;

    localparam int FFT_N = 8;
    localparam int FFT_W = 16;
    localparam int IDX_W = $clog2(FFT_N);

    typedef struct packed {
        logic signed [FFT_W-1:0] re;
        logic signed [FFT_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_WRITE,
        LD_START,
        LD_WAIT
    } ld_state_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of complex samples: indexed write, parallel read.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [IDX_W-1:0]       idx,
    input  cplx_t                  din,
    output cplx_t [FFT_N-1:0]      dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (we) begin
            dout[idx] <= din;
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Stream-to-frame ping-pong loader that feeds and sequences the FFT core.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_real,
    input  logic [WIDTH-1:0] s_imag,
    input  logic             s_last,
    output logic             write,
    output logic             start,
    input  logic             fft_ready,
    output logic [WIDTH-1:0] in0_real,
    output logic [WIDTH-1:0] in0_imag,
    output logic [WIDTH-1:0] in1_real,
    output logic [WIDTH-1:0] in1_imag,
    output logic [WIDTH-1:0] in2_real,
    output logic [WIDTH-1:0] in2_imag,
    output logic [WIDTH-1:0] in3_real,
    output logic [WIDTH-1:0] in3_imag,
    output logic [WIDTH-1:0] in4_real,
    output logic [WIDTH-1:0] in4_imag,
    output logic [WIDTH-1:0] in5_real,
    output logic [WIDTH-1:0] in5_imag,
    output logic [WIDTH-1:0] in6_real,
    output logic [WIDTH-1:0] in6_imag,
    output logic [WIDTH-1:0] in7_real,
    output logic [WIDTH-1:0] in7_imag,
    output logic             frame_done,
    output logic             frame_err
);

    ld_state_t         state;
    logic              fill_bank;
    logic              send_bank;
    logic [IDX_W-1:0]  fill_idx;
    logic [1:0]        full;
    logic              fft_ready_q;

    logic              acc;
    logic              at_end;
    logic              done_fill;
    logic              bad_fill;
    logic              rel;
    logic [1:0]        set_full;
    logic [1:0]        clr_full;
    cplx_t             din;
    cplx_t [FFT_N-1:0] rd0;
    cplx_t [FFT_N-1:0] rd1;
    cplx_t [FFT_N-1:0] rd;

    assign s_ready   = ~full[fill_bank];
    assign acc       = s_valid & s_ready;
    assign at_end    = fill_idx == IDX_W'(N - 1);
    assign done_fill = acc & at_end & s_last;
    assign bad_fill  = acc & (at_end ^ s_last);
    assign rel       = (state == LD_WAIT) & fft_ready & ~fft_ready_q;
    assign din       = '{re: s_real, im: s_imag};

    assign set_full = {done_fill & fill_bank, done_fill & ~fill_bank};
    assign clr_full = {rel & send_bank, rel & ~send_bank};

    fft_frame_bank u_bank0 (
        .clk   (CLK),
        .rst_n (RST_N),
        .we    (acc & ~fill_bank),
        .idx   (fill_idx),
        .din   (din),
        .dout  (rd0)
    );

    fft_frame_bank u_bank1 (
        .clk   (CLK),
        .rst_n (RST_N),
        .we    (acc & fill_bank),
        .idx   (fill_idx),
        .din   (din),
        .dout  (rd1)
    );

    assign rd = send_bank ? rd1 : rd0;

    assign in0_real = rd[0].re;
    assign in0_imag = rd[0].im;
    assign in1_real = rd[1].re;
    assign in1_imag = rd[1].im;
    assign in2_real = rd[2].re;
    assign in2_imag = rd[2].im;
    assign in3_real = rd[3].re;
    assign in3_imag = rd[3].im;
    assign in4_real = rd[4].re;
    assign in4_imag = rd[4].im;
    assign in5_real = rd[5].re;
    assign in5_imag = rd[5].im;
    assign in6_real = rd[6].re;
    assign in6_imag = rd[6].im;
    assign in7_real = rd[7].re;
    assign in7_imag = rd[7].im;

    // A malformed frame restarts the same bank; it is never marked full.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fill_bank <= 1'b0;
            fill_idx  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad_fill;
            if (acc) begin
                if (done_fill || bad_fill) begin
                    fill_idx <= '0;
                end else begin
                    fill_idx <= fill_idx + 1'b1;
                end
                if (done_fill) begin
                    fill_bank <= ~fill_bank;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full <= '0;
        end else begin
            full <= (full | set_full) & ~clr_full;
        end
    end

    // Release needs a fresh rising edge of fft_ready seen while waiting.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= LD_IDLE;
            send_bank   <= 1'b0;
            fft_ready_q <= 1'b0;
            write       <= 1'b0;
            start       <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            fft_ready_q <= fft_ready;
            write       <= 1'b0;
            start       <= 1'b0;
            frame_done  <= 1'b0;
            unique case (state)
                LD_IDLE: begin
                    if (full[send_bank]) begin
                        write <= 1'b1;
                        state <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    start <= 1'b1;
                    state <= LD_START;
                end
                LD_START: begin
                    state <= LD_WAIT;
                end
                LD_WAIT: begin
                    if (rel) begin
                        send_bank  <= ~send_bank;
                        frame_done <= 1'b1;
                        state      <= LD_IDLE;
                    end
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: frames queued on fill, checked on write.
module tb_fft_frame_loader;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        fft_ready = 1'b0;
    logic [15:0] s_real = '0;
    logic [15:0] s_imag = '0;
    logic        s_ready;
    logic        write;
    logic        start;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] in_re [8];
    logic [15:0] in_im [8];

    int n_tests = 0;
    int n_fail  = 0;
    int starts_seen = 0;
    int rel_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int wr_cnt = 0;

    logic [255:0] exp_q [$];

    always #5 CLK = ~CLK;

    fft_frame_loader dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_real     (s_real),
        .s_imag     (s_imag),
        .s_last     (s_last),
        .write      (write),
        .start      (start),
        .fft_ready  (fft_ready),
        .in0_real   (in_re[0]),
        .in0_imag   (in_im[0]),
        .in1_real   (in_re[1]),
        .in1_imag   (in_im[1]),
        .in2_real   (in_re[2]),
        .in2_imag   (in_im[2]),
        .in3_real   (in_re[3]),
        .in3_imag   (in_im[3]),
        .in4_real   (in_re[4]),
        .in4_imag   (in_im[4]),
        .in5_real   (in_re[5]),
        .in5_imag   (in_im[5]),
        .in6_real   (in_re[6]),
        .in6_imag   (in_im[6]),
        .in7_real   (in_re[7]),
        .in7_imag   (in_im[7]),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (start) starts_seen++;
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (write) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [255:0] f;
                f = exp_q.pop_front();
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("in%0d", k), {in_re[k], in_im[k]},
                        f[32*k +: 32]);
                end
            end
        end
    end

    // Called and returns at a falling edge; one sample per rising edge.
    task automatic push(input logic [15:0] r, input logic [15:0] im,
                        input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_real  = r;
        s_imag  = im;
        s_last  = last;
        while (!s_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!s_ready) chk("s_ready_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] r0, input logic [15:0] i0,
                              input logic [15:0] istep);
        logic [255:0] f;
        logic [15:0]  r;
        logic [15:0]  im;
        for (int k = 0; k < 8; k++) begin
            r  = r0 + 16'(k) * 16'h0100;
            im = i0 + 16'(k) * istep;
            f[32*k +: 32] = {r, im};
            push(r, im, k == 7);
        end
        exp_q.push_back(f);
    endtask

    task automatic release_frame(input string tag);
        int n = 0;
        while (starts_seen <= rel_cnt && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_start_seen"}, 32'(starts_seen > rel_cnt), 32'd1);
        @(negedge CLK);
        fft_ready = 1'b1;
        @(negedge CLK);
        chk({tag, "_done"}, 32'(frame_done), 32'd1);
        fft_ready = 1'b0;
        @(negedge CLK);
        chk({tag, "_done_off"}, 32'(frame_done), 32'd0);
        rel_cnt++;
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_in%0d", tag, k), {in_re[k], in_im[k]}, 32'd0);
        end
        chk({tag, "_write"}, 32'(write), 32'd0);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        int w0;

        // reset
        repeat (2) @(negedge CLK);
        chk_idle_outputs("rst");
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_s_ready_after", 32'(s_ready), 32'd1);

        // ramp frame with dispatch timing
        send_frame(16'h0000, 16'h0000, 16'h0000);
        chk("ramp_write_t1", 32'(write), 32'd0);
        @(negedge CLK);
        chk("ramp_write_t2", 32'(write), 32'd1);
        chk("ramp_start_t2", 32'(start), 32'd0);
        @(negedge CLK);
        chk("ramp_write_t3", 32'(write), 32'd0);
        chk("ramp_start_t3", 32'(start), 32'd1);
        release_frame("ramp");

        // backpressure: two full banks, third frame waits
        send_frame(16'h1000, 16'hff00, 16'h0010);
        send_frame(16'h2003, 16'h0042, 16'hfffd);
        chk("bp_s_ready_low", 32'(s_ready), 32'd0);
        repeat (3) @(negedge CLK);
        chk("bp_s_ready_held", 32'(s_ready), 32'd0);
        release_frame("bp_a");
        chk("bp_s_ready_back", 32'(s_ready), 32'd1);
        send_frame(16'h8001, 16'h7fff, 16'h1111);
        release_frame("bp_b");
        release_frame("bp_c");

        // malformed frames: early s_last, then missing s_last
        w0 = wr_cnt;
        for (int k = 0; k < 4; k++) push(16'(k) + 16'h0500, 16'h0000, 1'b0);
        push(16'h0504, 16'h0000, 1'b1);
        chk("err_early_last", 32'(frame_err), 32'd1);
        @(negedge CLK);
        chk("err_early_pulse", 32'(frame_err), 32'd0);
        for (int k = 0; k < 8; k++) push(16'h0600, 16'(k), 1'b0);
        chk("err_no_last", 32'(frame_err), 32'd1);
        repeat (6) @(negedge CLK);
        chk("err_no_write", 32'(wr_cnt), 32'(w0));
        send_frame(16'h0a00, 16'h0b00, 16'h0001);
        release_frame("err_good");

        // reset while waiting for the core
        d0 = done_cnt;
        send_frame(16'h3300, 16'h4400, 16'h0101);
        while (starts_seen <= rel_cnt) @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk_idle_outputs("rst_wait");
        @(negedge CLK);
        RST_N = 1'b1;
        exp_q.delete();
        rel_cnt = starts_seen;
        @(negedge CLK);
        chk("rst_wait_no_done", 32'(done_cnt), 32'(d0));
        send_frame(16'h0c00, 16'hf000, 16'h0020);
        release_frame("post_rst");

        // fft_ready stuck high through dispatch
        fft_ready = 1'b1;
        d0 = done_cnt;
        send_frame(16'h5500, 16'h0001, 16'h0002);
        while (starts_seen <= rel_cnt) @(negedge CLK);
        repeat (5) @(negedge CLK);
        chk("stuck_no_release", 32'(done_cnt), 32'(d0));
        fft_ready = 1'b0;
        @(negedge CLK);
        fft_ready = 1'b1;
        @(negedge CLK);
        chk("stuck_done", 32'(frame_done), 32'd1);
        repeat (4) @(negedge CLK);
        chk("stuck_one_done", 32'(done_cnt), 32'(d0 + 1));
        fft_ready = 1'b0;
        rel_cnt++;
        repeat (3) @(negedge CLK);

        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("end_done_cnt", 32'(done_cnt), 32'd7);
        chk("end_write_cnt", 32'(wr_cnt), 32'd8);
        chk("end_err_cnt", 32'(err_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
